// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : alu_share_arbiter
// Brief   : Round-robin sharing of one combinational ALU between two
//           valid/ready requester ports, one operation in flight at a time.
// Rev     : 1.0
// ============================================================================
module alu_share_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  req0_valid_i,
  output logic                  req0_ready_o,
  input  logic [OP_WIDTH-1:0]   req0_op_i,
  input  logic [DATA_WIDTH-1:0] req0_a_i,
  input  logic [DATA_WIDTH-1:0] req0_b_i,
  output logic                  rsp0_valid_o,
  input  logic                  rsp0_ready_i,
  output logic [DATA_WIDTH-1:0] rsp0_data_o,
  output logic                  rsp0_zero_o,

  input  logic                  req1_valid_i,
  output logic                  req1_ready_o,
  input  logic [OP_WIDTH-1:0]   req1_op_i,
  input  logic [DATA_WIDTH-1:0] req1_a_i,
  input  logic [DATA_WIDTH-1:0] req1_b_i,
  output logic                  rsp1_valid_o,
  input  logic                  rsp1_ready_i,
  output logic [DATA_WIDTH-1:0] rsp1_data_o,
  output logic                  rsp1_zero_o,

  output logic [OP_WIDTH-1:0]   alu_operation_o,
  output logic [DATA_WIDTH-1:0] alu_a_o,
  output logic [DATA_WIDTH-1:0] alu_b_o,
  input  logic [DATA_WIDTH-1:0] alu_data_i,
  input  logic                  alu_zero_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_ptr;
  logic                  r_owner;
  logic [OP_WIDTH-1:0]   r_op;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_res;
  logic                  r_zero;

  logic w_any_req;
  logic w_grant;
  logic w_accept;
  logic w_rsp_done;

  // Ready is gated by reset so no handshake is offered while reset is held.
  always_comb begin
    w_any_req   = req0_valid_i | req1_valid_i;
    w_grant     = (req0_valid_i & req1_valid_i) ? r_ptr : req1_valid_i;
    w_accept    = reset & (r_state == ST_IDLE) & w_any_req;
    w_rsp_done  = (r_state == ST_RESP) & (r_owner ? rsp1_ready_i : rsp0_ready_i);
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)   w_state_nxt = ST_EXEC;
      ST_EXEC:                 w_state_nxt = ST_RESP;
      ST_RESP: if (w_rsp_done) w_state_nxt = ST_IDLE;
      default:                 w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr   <= 1'b0;
      r_owner <= 1'b0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_zero  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_owner <= w_grant;
        r_op    <= w_grant ? req1_op_i : req0_op_i;
        r_a     <= w_grant ? req1_a_i  : req0_a_i;
        r_b     <= w_grant ? req1_b_i  : req0_b_i;
      end
      if (r_state == ST_EXEC) begin
        r_res  <= alu_data_i;
        r_zero <= alu_zero_i;
      end
      // Pointer only advances when a response completes, never on idle cycles.
      if (w_rsp_done) begin
        r_ptr <= ~r_owner;
      end
    end
  end

  assign req0_ready_o    = w_accept & ~w_grant;
  assign req1_ready_o    = w_accept &  w_grant;
  assign rsp0_valid_o    = (r_state == ST_RESP) & ~r_owner;
  assign rsp1_valid_o    = (r_state == ST_RESP) &  r_owner;
  assign rsp0_data_o     = r_res;
  assign rsp1_data_o     = r_res;
  assign rsp0_zero_o     = r_zero;
  assign rsp1_zero_o     = r_zero;

  // ALU inputs come only from the latched operands so they change at accept edges.
  assign alu_operation_o = r_op;
  assign alu_a_o         = r_a;
  assign alu_b_o         = r_b;

endmodule
`default_nettype wire
